// File: rtl/otter_pkg.sv
// otter_pkg: RV32 opcode encodings and the instruction classes shared by the decoder and issue logic
// Content: opcode_t plus writes_rd / uses_rs1 / uses_rs2 / is_mem / is_ctrl, each taking a 7-bit opcode
package otter_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_IMM    = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_IMM, OPC_OP};
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return op inside {OPC_LOAD, OPC_STORE};
    endfunction

    // Anything not a known straight-line opcode (including undefined encodings) is control.
    function automatic logic is_ctrl(input logic [6:0] op);
        return !(op inside {OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_IMM, OPC_OP});
    endfunction

endpackage

// File: rtl/issue_pair_check.sv
// issue_pair_check: flags whether a younger instruction may not issue in the same group as an older one
// Ports: older_i / younger_i raw instruction words; conflict_o high on RAW, double memory op, or older control
module issue_pair_check
    import otter_pkg::*;
(
    input  logic [31:0] older_i,
    input  logic [31:0] younger_i,
    output logic        conflict_o
);
    logic [6:0] op_o;
    logic [6:0] op_y;
    logic [4:0] rd;
    logic       raw;
    logic       unused_bits;

    assign unused_bits = ^{older_i[31:12], younger_i[31:25], younger_i[14:7]};

    always_comb begin
        op_o       = older_i[6:0];
        op_y       = younger_i[6:0];
        rd         = older_i[11:7];
        raw        = writes_rd(op_o) && (rd != 5'd0) &&
                     ((uses_rs1(op_y) && younger_i[19:15] == rd) ||
                      (uses_rs2(op_y) && younger_i[24:20] == rd));
        conflict_o = raw || (is_mem(op_o) && is_mem(op_y)) || is_ctrl(op_o);
    end

endmodule

// File: rtl/fetch_issue_queue.sv
// fetch_issue_queue: circular fetch buffer that issues up to ISSUE_W hazard-free instructions per cycle
// Ports: CLK, RESET_N (async active-low); FETCH_VALID/PC/IR incoming beat, FETCH_READY room for a beat;
//        FLUSH drops everything; ISSUE_STALL holds the head group; ISSUE_VALID/IR/PC head group; COUNT occupancy
module fetch_issue_queue
    import otter_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       FETCH_VALID,
    input  logic [31:0]                FETCH_PC,
    input  logic [32*FETCH_W-1:0]      FETCH_IR,
    output logic                       FETCH_READY,
    input  logic                       FLUSH,
    input  logic                       ISSUE_STALL,
    output logic [ISSUE_W-1:0]         ISSUE_VALID,
    output logic [32*ISSUE_W-1:0]      ISSUE_IR,
    output logic [32*ISSUE_W-1:0]      ISSUE_PC,
    output logic [$clog2(DEPTH+1)-1:0] COUNT
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]                      ir_q [DEPTH];
    logic [31:0]                      pc_q [DEPTH];
    logic [PW-1:0]                    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]                    count_q, count_d;
    logic [CW-1:0]                    deq;
    logic                             enq;
    logic                             prev;
    logic [31:0]                      slot_ir [ISSUE_W];
    logic [31:0]                      slot_pc [ISSUE_W];
    logic [ISSUE_W-1:0][ISSUE_W-1:0]  conflict;
    logic [ISSUE_W-1:0]               valid;

    // Readiness looks only at the registered occupancy; reset forces it low.
    assign FETCH_READY = RESET_N && (32'(DEPTH) - 32'(count_q) >= 32'(FETCH_W));
    assign ISSUE_VALID = valid;
    assign COUNT       = count_q;

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
        assign slot_ir[k]           = ir_q[head_q + PW'(k)];
        assign slot_pc[k]           = pc_q[head_q + PW'(k)];
        assign ISSUE_IR[32*k +: 32] = slot_ir[k];
        assign ISSUE_PC[32*k +: 32] = slot_pc[k];
        for (genvar j = 0; j < ISSUE_W; j++) begin : g_pair
            if (j < k) begin : g_chk
                issue_pair_check u_chk (
                    .older_i    (slot_ir[j]),
                    .younger_i  (slot_ir[k]),
                    .conflict_o (conflict[k][j])
                );
            end else begin : g_none
                assign conflict[k][j] = 1'b0;
            end
        end
    end

    // Group grows slot by slot; the first blocked slot ends it, keeping the mask a thermometer.
    always_comb begin
        valid = '0;
        prev  = 1'b1;
        for (int k = 0; k < ISSUE_W; k++) begin
            valid[k] = prev && (count_q > CW'(k)) && !(|conflict[k]) && !FLUSH &&
                       (k == 0 || !is_ctrl(slot_ir[k][6:0]));
            prev     = valid[k];
        end
    end

    always_comb begin
        deq = '0;
        for (int k = 0; k < ISSUE_W; k++)
            deq = deq + CW'(valid[k] && !ISSUE_STALL);
        enq     = FETCH_VALID && FETCH_READY && !FLUSH;
        head_d  = FLUSH ? '0 : head_q + PW'(deq);
        tail_d  = FLUSH ? '0 : tail_q + (enq ? PW'(FETCH_W) : '0);
        count_d = FLUSH ? '0 : count_q + (enq ? CW'(FETCH_W) : '0) - deq;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (enq)
            for (int k = 0; k < FETCH_W; k++) begin
                ir_q[tail_q + PW'(k)] <= FETCH_IR[32*k +: 32];
                pc_q[tail_q + PW'(k)] <= FETCH_PC + 32'(4*k);
            end
    end

endmodule

// File: doc/fetch_issue_queue.md
FETCH_ISSUE_QUEUE -- requirements
Module: fetch_issue_queue

Interface
REQ-001 Parameters SHALL be (name, default, meaning): FETCH_W, 2, instructions per fetch beat (1..4); ISSUE_W, 2, maximum instructions issued per cycle (1..FETCH_W); DEPTH, 8, queue entries (power of 2, >= 2*FETCH_W).
REQ-002 The design SHALL use one clock. Reset SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, clock.
- RESET_N, in, 1, asynchronous active-low reset.
- FETCH_VALID, in, 1, fetch beat present.
- FETCH_PC, in, 32, PC of slot 0 of the beat.
- FETCH_IR, in, 32*FETCH_W, instruction words; slot k is in bits [32k+31:32k].
- FETCH_READY, out, 1, the queue can accept a full beat.
- FLUSH, in, 1, discard all queued instructions (redirect).
- ISSUE_STALL, in, 1, downstream hold; nothing is dequeued.
- ISSUE_VALID, out, ISSUE_W, thermometer mask of the issue group.
- ISSUE_IR, out, 32*ISSUE_W, instructions in the issue group, oldest in slot 0.
- ISSUE_PC, out, 32*ISSUE_W, PCs of the instructions in the issue group.
- COUNT, out, clog2(DEPTH+1), current occupancy.

Function
REQ-004 Enqueue SHALL occur when FETCH_VALID && FETCH_READY. It writes FETCH_W entries; entry k holds FETCH_IR slot k and PC FETCH_PC+4k.
REQ-005 FETCH_READY SHALL equal (DEPTH-COUNT >= FETCH_W), computed from the registered COUNT only; same-cycle dequeue is not credited.
REQ-006 Issue slot 0 SHALL be valid when COUNT >= 1.
REQ-007 Issue slot k>0 SHALL be valid only if all of the following hold:
- slot k-1 is valid;
- COUNT > k;
- no RAW hazard exists with any slot j<k;
- the group holds no second LOAD/STORE;
- no slot j<k is a control instruction.
REQ-008 A RAW hazard SHALL exist when an earlier slot writes rd != x0 and slot k uses rs1 or rs2 equal to that rd.
- rd writers: LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP.
- rs1 users: all opcodes except LUI, AUIPC, JAL.
- rs2 users: BRANCH, STORE, OP.
REQ-009 Control instructions SHALL be BRANCH, JAL, JALR, SYSTEM and any undefined opcode. A control instruction may occupy slot 0 only, and it ends the group.
REQ-010 ISSUE_* SHALL be combinational from the head entries. An enqueued instruction SHALL be visible at ISSUE no earlier than the cycle after its enqueue (1-cycle latency).
REQ-011 When !ISSUE_STALL && !FLUSH, popcount(ISSUE_VALID) entries SHALL be dequeued at the clock edge.
REQ-012 Same-cycle enqueue and dequeue SHALL both take effect: COUNT_next = COUNT + FETCH_W*enq - popcount.
REQ-013 Read and write pointers SHALL wrap modulo DEPTH. Issue slots SHALL read entries (head+k) mod DEPTH across the wrap boundary.
REQ-014 FLUSH SHALL have priority over enqueue and dequeue. While FLUSH is high, ISSUE_VALID SHALL be 0. At the edge: pointers <= 0, COUNT <= 0, and any same-cycle fetch beat is discarded.
REQ-015 ISSUE_STALL SHALL hold the queue contents and the issue group stable. Enqueue SHALL continue subject to FETCH_READY.
REQ-016 COUNT SHALL never exceed DEPTH, and dequeue SHALL never exceed COUNT.

Reset
REQ-017 While RESET_N is low:
- COUNT=0, pointers=0;
- ISSUE_VALID=0, FETCH_READY=0.
Storage contents SHALL NOT require reset.
REQ-018 On the first edge after RESET_N deasserts, FETCH_READY SHALL be 1. Reset asserted mid-operation SHALL discard all entries immediately.

Structure
REQ-019 opcode_t (LUI..SYSTEM encodings) and the rd-write/rs-use/control classification functions SHALL reside in shared package otter_pkg. The CPU decoder SHALL import the same package.
REQ-020 The pairwise hazard test between an older and a younger instruction SHALL be a combinational sub-module, issue_pair_check. It SHALL be instantiated for every (j<k) slot pair.

Verification (FETCH_W=ISSUE_W=2, DEPTH=8)
REQ-021 Fetch 0x00100093, 0x00200113 at PC 0x0 -> next cycle ISSUE_VALID=2'b11, ISSUE_PC={0x4,0x0}; after the dequeue edge COUNT=0.
REQ-022 Fetch 0x00100093, 0x00108133 (add x2,x1,x1) -> ISSUE_VALID=2'b01 on two consecutive cycles, in order.
REQ-023 Fetch 0x00002083, 0x00402103 (two lw) -> issued separately. Fetch 0x00000463 (beq) followed by addi -> beq issues alone.
REQ-024 ISSUE_STALL=1, four beats -> COUNT=8, FETCH_READY=0. Release the stall and refill -> entries wrap past index 7 and PCs stay in order.
REQ-025 FLUSH=1 with FETCH_VALID=1 and COUNT=4 -> ISSUE_VALID=0 that cycle, COUNT=0 next cycle. RESET_N low mid-stream -> outputs cleared asynchronously.
